// File: rtl/video_timing_rx.sv
// video_timing_rx: measures incoming raw video timing, locks onto a stable geometry and
// re-times the pixel stream with per-pixel column/line coordinates and frame/line markers.
module video_timing_rx #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hsync_pol_i,
  input  logic        vsync_pol_i,
  input  logic        de_i,
  input  logic [7:0]  red_i,
  input  logic [7:0]  green_i,
  input  logic [7:0]  blue_i,
  output logic        de_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic [11:0] h_total_o,
  output logic [11:0] h_active_o,
  output logic [11:0] v_total_o,
  output logic [11:0] v_active_o,
  output logic        locked_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Stage 1 registers
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q, de_q;
  logic [7:0] red_q, green_q, blue_q;

  // Pixel output stage
  logic        de_o_q, sof_q, eol_q;
  logic [7:0]  red_o_q, green_o_q, blue_o_q;
  logic [11:0] x_o_q, y_o_q, y_cnt_q;

  // Measurement counters
  logic [11:0] h_cnt_q, de_cnt_q, last_ht_q, last_ha_q, v_cnt_q, va_cnt_q, wd_cnt_q;

  // Lock FSM state
  state_e      state_q;
  logic [3:0]  match_cnt_q;
  logic [11:0] cand_ht_q, cand_ha_q, cand_vt_q, cand_va_q;
  logic [11:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic        locked_q;
  logic [7:0]  err_cnt_q;

  logic        hs_edge, vs_edge, de_rise, de_fall, line_has_de;
  logic [11:0] line_ht, line_ha, frame_vt, frame_va;
  logic        cand_match, match_reached, line_err, frame_err, wd_fire;

  assign hs_edge     = hs_q & ~hs_prev_q;
  assign vs_edge     = vs_q & ~vs_prev_q;
  assign de_rise     = de_q & ~de_o_q;
  assign de_fall     = ~de_q & de_o_q;
  assign line_has_de = (de_cnt_q != 12'd0);

  // Most recent complete line; h_active only tracks lines that carried video.
  assign line_ht  = hs_edge ? h_cnt_q : last_ht_q;
  assign line_ha  = (hs_edge && line_has_de) ? de_cnt_q : last_ha_q;
  // A line closed by an hs_edge coincident with vs_edge still belongs to the old frame.
  assign frame_vt = v_cnt_q;
  assign frame_va = (hs_edge && line_has_de) ? sat_inc12(va_cnt_q) : va_cnt_q;

  assign cand_match    = (line_ht == cand_ht_q) && (line_ha == cand_ha_q) &&
                         (frame_vt == cand_vt_q) && (frame_va == cand_va_q);
  assign match_reached = (32'(match_cnt_q) + 32'd1) >= LOCK_FRAMES;
  assign line_err      = hs_edge && ((h_cnt_q != h_total_q) ||
                                     (line_has_de && (de_cnt_q != h_active_q)));
  assign frame_err     = vs_edge && ((frame_vt != v_total_q) || (frame_va != v_active_q));
  assign wd_fire       = ~hs_edge && (wd_cnt_q == 12'hFFF);

  // Normalise sync polarity and register syncs, enable and pixel data together.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Sync history resets high so an already-active sync at release is not an edge.
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      de_q      <= 1'b0;
      red_q     <= 8'd0;
      green_q   <= 8'd0;
      blue_q    <= 8'd0;
    end else begin
      hs_q      <= ~(hsync_i ^ hsync_pol_i);
      vs_q      <= ~(vsync_i ^ vsync_pol_i);
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      de_q      <= de_i;
      red_q     <= red_i;
      green_q   <= green_i;
      blue_q    <= blue_i;
    end
  end

  // Second pixel stage: blank RGB, generate coordinates and line/frame markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_o_q    <= 1'b0;
      red_o_q   <= 8'd0;
      green_o_q <= 8'd0;
      blue_o_q  <= 8'd0;
      x_o_q     <= 12'd0;
      y_o_q     <= 12'd0;
      y_cnt_q   <= 12'd0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      de_o_q    <= de_q;
      red_o_q   <= de_q ? red_q : 8'd0;
      green_o_q <= de_q ? green_q : 8'd0;
      blue_o_q  <= de_q ? blue_q : 8'd0;
      sof_q     <= de_rise && (y_cnt_q == 12'd0);
      // de_i is the pixel that follows the one now entering this stage.
      eol_q     <= de_q & ~de_i;
      if (de_q) begin
        x_o_q <= de_rise ? 12'd0 : sat_inc12(x_o_q);
        y_o_q <= y_cnt_q;
      end
      if (vs_edge) begin
        y_cnt_q <= 12'd0;
      end else if (de_fall) begin
        y_cnt_q <= sat_inc12(y_cnt_q);
      end
    end
  end

  // Line/frame measurement counters and hsync watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q   <= 12'd0;
      de_cnt_q  <= 12'd0;
      last_ht_q <= 12'd0;
      last_ha_q <= 12'd0;
      v_cnt_q   <= 12'd0;
      va_cnt_q  <= 12'd0;
      wd_cnt_q  <= 12'd0;
    end else begin
      if (hs_edge) begin
        h_cnt_q   <= 12'd1;
        de_cnt_q  <= {11'd0, de_q};
        last_ht_q <= h_cnt_q;
        if (line_has_de) begin
          last_ha_q <= de_cnt_q;
        end
        wd_cnt_q  <= 12'd0;
      end else begin
        h_cnt_q  <= sat_inc12(h_cnt_q);
        wd_cnt_q <= sat_inc12(wd_cnt_q);
        if (de_q) begin
          de_cnt_q <= sat_inc12(de_cnt_q);
        end
      end
      if (vs_edge) begin
        v_cnt_q  <= hs_edge ? 12'd1 : 12'd0;
        va_cnt_q <= 12'd0;
      end else begin
        if (hs_edge) begin
          v_cnt_q <= sat_inc12(v_cnt_q);
        end
        if (hs_edge && line_has_de) begin
          va_cnt_q <= sat_inc12(va_cnt_q);
        end
      end
    end
  end

  // Lock FSM: search, measure a candidate, verify it over consecutive frames, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      match_cnt_q <= 4'd0;
      cand_ht_q   <= 12'd0;
      cand_ha_q   <= 12'd0;
      cand_vt_q   <= 12'd0;
      cand_va_q   <= 12'd0;
      h_total_q   <= 12'd0;
      h_active_q  <= 12'd0;
      v_total_q   <= 12'd0;
      v_active_q  <= 12'd0;
      locked_q    <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (vs_edge) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (wd_fire) begin
            state_q <= StSearch;
          end else if (vs_edge) begin
            cand_ht_q   <= line_ht;
            cand_ha_q   <= line_ha;
            cand_vt_q   <= frame_vt;
            cand_va_q   <= frame_va;
            match_cnt_q <= 4'd0;
            state_q     <= StVerify;
          end
        end
        StVerify: begin
          if (wd_fire) begin
            state_q <= StSearch;
          end else if (vs_edge) begin
            if (cand_match) begin
              if (match_reached) begin
                state_q    <= StLocked;
                locked_q   <= 1'b1;
                h_total_q  <= cand_ht_q;
                h_active_q <= cand_ha_q;
                v_total_q  <= cand_vt_q;
                v_active_q <= cand_va_q;
              end else begin
                match_cnt_q <= match_cnt_q + 4'd1;
              end
            end else begin
              cand_ht_q   <= line_ht;
              cand_ha_q   <= line_ha;
              cand_vt_q   <= frame_vt;
              cand_va_q   <= frame_va;
              match_cnt_q <= 4'd0;
            end
          end
        end
        StLocked: begin
          if (wd_fire || line_err || frame_err) begin
            state_q   <= StSearch;
            locked_q  <= 1'b0;
            err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign de_o       = de_o_q;
  assign red_o      = red_o_q;
  assign green_o    = green_o_q;
  assign blue_o     = blue_o_q;
  assign x_o        = x_o_q;
  assign y_o        = y_o_q;
  assign sof_o      = sof_q;
  assign eol_o      = eol_q;
  assign h_total_o  = h_total_q;
  assign h_active_o = h_active_q;
  assign v_total_o  = v_total_q;
  assign v_active_o = v_active_q;
  assign locked_o   = locked_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx: synthesises small random video geometries and checks lock
// behaviour, measurement outputs and the re-timed pixel stream.
module tb_video_timing_rx;

  localparam int HSW    = 4;  // hsync active columns, rising at column 0
  localparam int HSTART = 6;  // first active column
  localparam int VSW    = 2;  // vsync active lines, rising at line 0
  localparam int VSTART = 3;  // first active line

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_i, vsync_i, hsync_pol_i, vsync_pol_i, de_i;
  logic [7:0]  red_i, green_i, blue_i;
  logic        de_o, sof_o, eol_o, locked_o;
  logic [7:0]  red_o, green_o, blue_o, err_cnt_o;
  logic [11:0] x_o, y_o, h_total_o, h_active_o, v_total_o, v_active_o;

  int n_checks = 0;
  int n_fail   = 0;
  int g_ht, g_ha, g_vt, g_va;
  int exp_err;
  int since_hs = 0;
  bit last_hs_drv = 1'b0;
  bit saw_lock;
  bit lock_l0;
  bit lock_after_short;

  logic [107:0] all_outs;
  assign all_outs = {de_o, red_o, green_o, blue_o, x_o, y_o, sof_o, eol_o, h_total_o,
                     h_active_o, v_total_o, v_active_o, locked_o, err_cnt_o};

  video_timing_rx #(.LOCK_FRAMES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .hsync_pol_i (hsync_pol_i),
    .vsync_pol_i (vsync_pol_i),
    .de_i        (de_i),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .de_o        (de_o),
    .red_o       (red_o),
    .green_o     (green_o),
    .blue_o      (blue_o),
    .x_o         (x_o),
    .y_o         (y_o),
    .sof_o       (sof_o),
    .eol_o       (eol_o),
    .h_total_o   (h_total_o),
    .h_active_o  (h_active_o),
    .v_total_o   (v_total_o),
    .v_active_o  (v_active_o),
    .locked_o    (locked_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // One pixel clock of stimulus; hs/vs are given active-high and encoded per polarity.
  task automatic drive_cyc(input bit hs, input bit vs, input bit de,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    hsync_i = hsync_pol_i ? hs : ~hs;
    vsync_i = vsync_pol_i ? vs : ~vs;
    de_i    = de;
    red_i   = r;
    green_i = g;
    blue_i  = b;
    @(posedge clk);
    #1;
    if (hs && !last_hs_drv) since_hs = 0;
    else since_hs++;
    last_hs_drv = hs;
    if (locked_o === 1'b1) saw_lock = 1'b1;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle(2);
    reset = 1'b0;
    drive_idle(4);
  endtask

  task automatic new_geometry();
    g_ht = int'($urandom_range(64, 48));
    g_ha = int'($urandom_range(g_ht - HSTART - 3, 16));
    g_vt = int'($urandom_range(20, 14));
    g_va = int'($urandom_range(g_vt - VSTART - 2, 4));
  endtask

  // Drives nlines of a frame of vt lines; line short_l is one cycle short. With chk set,
  // every output pixel is compared against the pixel driven one call earlier.
  task automatic drive_frame(input int vt, input int short_l, input bit chk, input int nlines);
    bit          pv;
    bit          e_de, e_sof, e_eol;
    logic [7:0]  e_r, e_g, e_b;
    logic [11:0] e_x, e_y;
    int          sof_n, eol_n;
    pv = 1'b0; sof_n = 0; eol_n = 0;
    e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
    e_x = 12'd0; e_y = 12'd0;
    for (int l = 0; l < nlines && l < vt; l++) begin
      int len;
      len = (l == short_l) ? g_ht - 1 : g_ht;
      for (int c = 0; c < len; c++) begin
        bit         act;
        int         xx, yy;
        logic [7:0] r, g, b;
        xx  = c - HSTART;
        yy  = l - VSTART;
        act = (l >= VSTART) && (l < VSTART + g_va) && (c >= HSTART) && (c < HSTART + g_ha);
        r   = act ? 8'(xx) : 8'($urandom);
        g   = 8'($urandom);
        b   = 8'($urandom);
        drive_cyc(c < HSW, l < VSW, act, r, g, b);
        if (chk && pv) begin
          n_checks++;
          if (de_o !== e_de || red_o !== e_r || green_o !== e_g || blue_o !== e_b ||
              sof_o !== e_sof || eol_o !== e_eol || (e_de && (x_o !== e_x || y_o !== e_y))) begin
            n_fail++;
            $display("FAIL pixel l=%0d c=%0d: got de=%b rgb=%h/%h/%h x=%0d y=%0d sof=%b eol=%b, expected de=%b rgb=%h/%h/%h x=%0d y=%0d sof=%b eol=%b",
                     l, c, de_o, red_o, green_o, blue_o, x_o, y_o, sof_o, eol_o,
                     e_de, e_r, e_g, e_b, e_x, e_y, e_sof, e_eol);
          end
          if (sof_o === 1'b1) sof_n++;
          if (eol_o === 1'b1) eol_n++;
        end
        pv    = 1'b1;
        e_de  = act;
        e_r   = act ? r : 8'd0;
        e_g   = act ? g : 8'd0;
        e_b   = act ? b : 8'd0;
        e_x   = 12'(xx);
        e_y   = 12'(yy);
        e_sof = act && xx == 0 && yy == 0;
        e_eol = act && xx == g_ha - 1;
      end
      if (l == 0) lock_l0 = locked_o;
      if (l == short_l + 1) lock_after_short = locked_o;
    end
    if (chk) begin
      n_checks++;
      if (sof_n != 1) begin
        n_fail++;
        $display("FAIL sof_count: got %0d expected 1", sof_n);
      end
      n_checks++;
      if (eol_n != g_va) begin
        n_fail++;
        $display("FAIL eol_count: got %0d expected %0d", eol_n, g_va);
      end
    end
  endtask

  task automatic test_reset();
    new_geometry();
    hsync_pol_i = 1'b0;
    vsync_pol_i = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      drive_cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom));
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    reset = 1'b0;
    drive_idle(4);
    n_checks++;
    if (locked_o !== 1'b0 || err_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got locked=%b err=%0d expected locked=0 err=0",
               locked_o, err_cnt_o);
    end
  endtask

  task automatic test_lock();
    new_geometry();
    hsync_pol_i = 1'b0;
    vsync_pol_i = 1'b0;
    do_reset();
    exp_err  = 0;
    saw_lock = 1'b0;
    repeat (3) drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (saw_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: got locked before 4th vs_edge expected unlocked");
    end
    drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (lock_l0 !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_at_4th: got %b expected 1", lock_l0);
    end
    n_checks++;
    if (h_total_o !== 12'(g_ht) || h_active_o !== 12'(g_ha) ||
        v_total_o !== 12'(g_vt) || v_active_o !== 12'(g_va)) begin
      n_fail++;
      $display("FAIL lock_measure: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               h_total_o, h_active_o, v_total_o, v_active_o, g_ht, g_ha, g_vt, g_va);
    end
    n_checks++;
    if (err_cnt_o !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL lock_err: got %0d expected %0d", err_cnt_o, exp_err);
    end
  endtask

  task automatic test_pixel_path();
    drive_frame(g_vt, -1, 1'b1, g_vt);
    n_checks++;
    if (locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pixel_locked: got %b expected 1", locked_o);
    end
  endtask

  task automatic test_short_line();
    int sl;
    sl = int'($urandom_range(VSTART + g_va - 1, VSTART));
    lock_after_short = 1'b1;
    drive_frame(g_vt, sl, 1'b0, g_vt);
    exp_err++;
    n_checks++;
    if (lock_after_short !== 1'b0) begin
      n_fail++;
      $display("FAIL short_unlock: got %b expected 0 within one line", lock_after_short);
    end
    n_checks++;
    if (err_cnt_o !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL short_err: got %0d expected %0d", err_cnt_o, exp_err);
    end
    n_checks++;
    if (h_total_o !== 12'(g_ht) || v_total_o !== 12'(g_vt)) begin
      n_fail++;
      $display("FAIL short_hold: got %0d/%0d expected %0d/%0d",
               h_total_o, v_total_o, g_ht, g_vt);
    end
    saw_lock = 1'b0;
    repeat (3) drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (saw_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL short_relock_early: got locked expected unlocked");
    end
    drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (lock_l0 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_relock: got %b expected 1", lock_l0);
    end
  endtask

  task automatic test_watchdog();
    while (since_hs < 4090) drive_idle(1);
    n_checks++;
    if (locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_early: got %b expected 1 at %0d cycles", locked_o, since_hs);
    end
    while (since_hs < 4100) drive_idle(1);
    exp_err++;
    n_checks++;
    if (locked_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire: got %b expected 0 at %0d cycles", locked_o, since_hs);
    end
    n_checks++;
    if (err_cnt_o !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL wd_err: got %0d expected %0d", err_cnt_o, exp_err);
    end
    repeat (4) drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (lock_l0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_relock: got %b expected 1", lock_l0);
    end
  endtask

  task automatic test_reset_midframe();
    drive_frame(g_vt, -1, 1'b0, g_vt / 2);
    reset = 1'b1;
    drive_cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom));
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0", all_outs);
    end
    hsync_pol_i = 1'($urandom);
    vsync_pol_i = 1'($urandom);
    drive_idle(1);
    reset = 1'b0;
    drive_idle(3);
    exp_err  = 0;
    saw_lock = 1'b0;
    repeat (3) drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (saw_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_early: got locked expected unlocked");
    end
    drive_frame(g_vt, -1, 1'b0, g_vt);
    n_checks++;
    if (lock_l0 !== 1'b1 || err_cnt_o !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL midreset_relock: got locked=%b err=%0d expected locked=1 err=%0d",
               lock_l0, err_cnt_o, exp_err);
    end
    n_checks++;
    if (h_total_o !== 12'(g_ht) || v_active_o !== 12'(g_va)) begin
      n_fail++;
      $display("FAIL midreset_measure: got %0d/%0d expected %0d/%0d",
               h_total_o, v_active_o, g_ht, g_va);
    end
  endtask

  task automatic test_alternate();
    new_geometry();
    hsync_pol_i = 1'($urandom);
    vsync_pol_i = 1'($urandom);
    do_reset();
    exp_err  = 0;
    saw_lock = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int vt;
      vt = (i % 2 == 1) ? g_vt + 1 : g_vt;
      drive_frame(vt, -1, 1'b0, vt);
    end
    n_checks++;
    if (saw_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_nolock: got locked expected never locked");
    end
    n_checks++;
    if (err_cnt_o !== 8'(exp_err) || h_total_o !== 12'd0) begin
      n_fail++;
      $display("FAIL alt_state: got err=%0d h_total=%0d expected err=0 h_total=0",
               err_cnt_o, h_total_o);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel_path();
    test_short_line();
    test_watchdog();
    test_reset_midframe();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_rx.md
VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, consecutive matching frames required before lock (range 1-15).
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hsync_i, vsync_i  input  1 each  raw sync, polarity per *_pol_i.
REQ-005 hsync_pol_i, vsync_pol_i  input  1 each  1 = positive, 0 = negative sync polarity; static while locked.
REQ-006 de_i  input  1  active-video enable, active-high.
REQ-007 red_i, green_i, blue_i  input  8 each  pixel data.
REQ-008 de_o  output  1  delayed de_i.
REQ-009 red_o, green_o, blue_o  output  8 each  delayed pixel; 0 when de_o low.
REQ-010 x_o, y_o  output  12 each  active column/line of the current de_o pixel.
REQ-011 sof_o, eol_o  output  1 each  pulses: first active pixel of frame; last active pixel of line.
REQ-012 h_total_o, h_active_o, v_total_o, v_active_o  output  12 each  locked timing measurement.
REQ-013 locked_o  output  1  timing stable.
REQ-014 err_cnt_o  output  8  saturating lock-loss count.

Function
REQ-015 Sync normalise: hs = hsync_i XNOR hsync_pol_i, vs = vsync_i XNOR vsync_pol_i (active-high internally), registered once with de_i and RGB.
REQ-016 Edges: hs_edge/vs_edge = rising edge of normalised hs/vs; de_rise/de_fall from registered de.
REQ-017 Line measure: h_total = clk cycles between consecutive hs_edges; h_active = de-high cycles in that line; all counters 12-bit, saturate at 4095.
REQ-018 Frame measure: v_total = hs_edges between consecutive vs_edges, counting an hs_edge coincident with vs_edge for the new frame; v_active = lines with at least one de-high cycle.
REQ-019 FSM states SEARCH, MEASURE, VERIFY, LOCKED; reset state SEARCH.
REQ-020 SEARCH: locked_o=0; on vs_edge -> MEASURE.
REQ-021 MEASURE: on next vs_edge latch candidate {h_total, h_active, v_total, v_active} (h values from last complete line), match_cnt=0 -> VERIFY.
REQ-022 VERIFY: on each vs_edge compare frame values with candidate; match -> match_cnt+1; mismatch -> reload candidate, match_cnt=0, stay VERIFY; match_cnt reaching LOCK_FRAMES -> LOCKED, copy candidate to *_total_o/*_active_o.
REQ-023 LOCKED: per-line h mismatch (lines with de only for h_active) or per-frame v mismatch -> SEARCH, locked_o=0, err_cnt_o+1 (saturate 255); measurement outputs hold last locked values.
REQ-024 Watchdog: no hs_edge for 4096 cycles in any state except SEARCH -> SEARCH; increments err_cnt_o only if leaving LOCKED.
REQ-025 Pixel path: fixed 2-cycle latency de_i/RGB -> de_o/RGB_o, independent of lock state.
REQ-026 x_o = 0 on first pixel after de_rise, +1 per active pixel, saturate 4095; y_o = 0 after vs_edge, +1 after each de_fall.
REQ-027 sof_o high with de_o pixel at x=0, y=0; eol_o high with last de_o pixel of a line (de_o falling next cycle); both 1 cycle, aligned to de_o.
REQ-028 Simultaneous hs_edge and vs_edge: frame compare uses completed frame; line counted in new frame.

Reset
REQ-029 Reset clears FSM to SEARCH, all counters, candidate, match_cnt, err_cnt_o; all outputs 0 in the cycle after reset sampled high.
REQ-030 Reset mid-frame discards partial frame; measurement restarts at first vs_edge after reset release.

Verification
REQ-031 VGA 800/640 x 525/480, both polarities 0 -> locked_o rises at 4th vs_edge after reset; outputs 800, 640, 525, 480; err_cnt_o=0.
REQ-032 Locked VGA, one line shortened to 799 cycles -> locked_o falls within 1 line, err_cnt_o=1, re-lock 3 frames later.
REQ-033 Pixel pattern RGB=x[7:0] -> de_o 2 cycles after de_i, x_o 0..639, y_o 0..479, sof_o once per frame, eol_o 480 times per frame.
REQ-034 hsync_i held constant 5000 cycles while locked -> SEARCH at watchdog cycle 4096, err_cnt_o+1.
REQ-035 Reset asserted mid-frame while locked -> next cycle all outputs 0; re-lock at 4th vs_edge after release.
REQ-036 Alternate candidate mismatch every frame (v_total 525/526) -> never locks, err_cnt_o stays 0.
